// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : cache_controller
// Brief    : Request sequencing FSM for the cache datapath: hit/miss
//            resolution, dirty-victim writeback and word-serial line refill.
// Revision : 1.0
// ============================================================================
module cache_controller #(
  parameter int READ_ONLY        = 0,
  parameter int COUNT_REPLAY_HIT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic req_valid,
  input  logic req_is_store,
  output logic req_fulfilled,
  output logic hmem_req_valid,
  output logic hmem_req_is_store,
  input  logic hmem_req_fulfilled,
  input  logic valid_block_match,
  input  logic valid_dirty_bit,
  input  logic counter_done,
  output logic miss_recovery_mode,
  output logic process_lru_counters,
  output logic clear_selected_valid_bit,
  output logic finish_new_line_install,
  output logic clear_selected_dirty_bit,
  output logic set_selected_dirty_bit,
  output logic set_hmem_block_address,
  output logic use_victim_tag_for_hmem_block_address,
  output logic perform_write,
  output logic reset_counter,
  output logic decrement_counter,
  output logic count_hit,
  output logic count_miss,
  output logic count_read,
  output logic count_write,
  output logic count_writeback
);

  localparam logic c_writable   = (READ_ONLY == 0);
  localparam logic c_replay_hit = (COUNT_REPLAY_HIT != 0);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COMPARE   = 2'd1,
    ST_WRITEBACK = 2'd2,
    ST_ALLOCATE  = 2'd3
  } state_t;

  state_t r_state, w_next_state;
  logic   r_replay, w_next_replay;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_replay <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_replay <= w_next_replay;
    end
  end

  always_comb begin
    w_next_state                          = r_state;
    w_next_replay                         = r_replay;
    req_fulfilled                         = 1'b0;
    hmem_req_valid                        = 1'b0;
    hmem_req_is_store                     = 1'b0;
    miss_recovery_mode                    = 1'b0;
    process_lru_counters                  = 1'b0;
    clear_selected_valid_bit              = 1'b0;
    finish_new_line_install               = 1'b0;
    clear_selected_dirty_bit              = 1'b0;
    set_selected_dirty_bit                = 1'b0;
    set_hmem_block_address                = 1'b0;
    use_victim_tag_for_hmem_block_address = 1'b0;
    perform_write                         = 1'b0;
    reset_counter                         = 1'b0;
    decrement_counter                     = 1'b0;
    count_hit                             = 1'b0;
    count_miss                            = 1'b0;
    count_read                            = 1'b0;
    count_write                           = 1'b0;
    count_writeback                       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (req_valid) w_next_state = ST_COMPARE;
      end

      ST_COMPARE: begin
        if (!r_replay) begin
          count_read  = !req_is_store;
          count_write = req_is_store;
        end
        if (valid_block_match) begin
          req_fulfilled        = 1'b1;
          process_lru_counters = 1'b1;
          count_hit            = !r_replay || c_replay_hit;
          if (req_is_store && c_writable) begin
            perform_write          = 1'b1;
            set_selected_dirty_bit = 1'b1;
          end
          w_next_state  = ST_IDLE;
          w_next_replay = 1'b0;
        end else begin
          // A miss on replay is a protocol violation; rerun the miss path cleanly.
          count_miss             = 1'b1;
          set_hmem_block_address = 1'b1;
          reset_counter          = 1'b1;
          w_next_replay          = 1'b0;
          if (valid_dirty_bit && c_writable) begin
            use_victim_tag_for_hmem_block_address = 1'b1;
            count_writeback                       = 1'b1;
            w_next_state                          = ST_WRITEBACK;
          end else begin
            clear_selected_valid_bit = 1'b1;
            w_next_state             = ST_ALLOCATE;
          end
        end
      end

      ST_WRITEBACK: begin
        miss_recovery_mode = 1'b1;
        hmem_req_valid     = 1'b1;
        hmem_req_is_store  = 1'b1;
        if (hmem_req_fulfilled) begin
          if (!counter_done) begin
            decrement_counter = 1'b1;
          end else begin
            clear_selected_dirty_bit = 1'b1;
            clear_selected_valid_bit = 1'b1;
            set_hmem_block_address   = 1'b1;
            reset_counter            = 1'b1;
            w_next_state             = ST_ALLOCATE;
          end
        end
      end

      ST_ALLOCATE: begin
        miss_recovery_mode = 1'b1;
        hmem_req_valid     = 1'b1;
        if (hmem_req_fulfilled) begin
          perform_write = 1'b1;
          if (!counter_done) begin
            decrement_counter = 1'b1;
          end else begin
            finish_new_line_install = 1'b1;
            w_next_replay           = 1'b1;
            w_next_state            = ST_COMPARE;
          end
        end
      end

      default: w_next_state = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_controller
// Brief    : Directed self-checking bench for cache_controller (read-write and
//            read-only builds) with an 8-word line and a latency-driven memory.
// Revision : 1.0
// ============================================================================
module tb_cache_controller;

  logic clk = 1'b0;
  logic reset;
  logic req_valid, req_is_store;
  logic hmem_req_fulfilled, valid_block_match, valid_dirty_bit, counter_done;
  logic sel_ro;

  wire [18:0] oa;
  wire [18:0] ob;
  wire [18:0] o = sel_ro ? ob : oa;

  wire w_req_fulfilled  = o[0];
  wire w_hmem_valid     = o[1];
  wire w_hmem_store     = o[2];
  wire w_lru            = o[4];
  wire w_clear_valid    = o[5];
  wire w_finish         = o[6];
  wire w_clear_dirty    = o[7];
  wire w_set_dirty      = o[8];
  wire w_victim         = o[10];
  wire w_perform_write  = o[11];
  wire w_reset_counter  = o[12];
  wire w_decrement      = o[13];
  wire w_count_hit      = o[14];
  wire w_count_miss     = o[15];
  wire w_count_read     = o[16];
  wire w_count_write    = o[17];
  wire w_count_wb       = o[18];
  wire w_miss_recovery  = o[3];

  always #5 clk = ~clk;

  cache_controller #(.READ_ONLY(0), .COUNT_REPLAY_HIT(0)) u_dut_rw (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_is_store(req_is_store),
    .req_fulfilled(oa[0]), .hmem_req_valid(oa[1]), .hmem_req_is_store(oa[2]),
    .hmem_req_fulfilled(hmem_req_fulfilled), .valid_block_match(valid_block_match),
    .valid_dirty_bit(valid_dirty_bit), .counter_done(counter_done),
    .miss_recovery_mode(oa[3]), .process_lru_counters(oa[4]),
    .clear_selected_valid_bit(oa[5]), .finish_new_line_install(oa[6]),
    .clear_selected_dirty_bit(oa[7]), .set_selected_dirty_bit(oa[8]),
    .set_hmem_block_address(oa[9]), .use_victim_tag_for_hmem_block_address(oa[10]),
    .perform_write(oa[11]), .reset_counter(oa[12]), .decrement_counter(oa[13]),
    .count_hit(oa[14]), .count_miss(oa[15]), .count_read(oa[16]),
    .count_write(oa[17]), .count_writeback(oa[18])
  );

  cache_controller #(.READ_ONLY(1), .COUNT_REPLAY_HIT(0)) u_dut_ro (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_is_store(req_is_store),
    .req_fulfilled(ob[0]), .hmem_req_valid(ob[1]), .hmem_req_is_store(ob[2]),
    .hmem_req_fulfilled(hmem_req_fulfilled), .valid_block_match(valid_block_match),
    .valid_dirty_bit(valid_dirty_bit), .counter_done(counter_done),
    .miss_recovery_mode(ob[3]), .process_lru_counters(ob[4]),
    .clear_selected_valid_bit(ob[5]), .finish_new_line_install(ob[6]),
    .clear_selected_dirty_bit(ob[7]), .set_selected_dirty_bit(ob[8]),
    .set_hmem_block_address(ob[9]), .use_victim_tag_for_hmem_block_address(ob[10]),
    .perform_write(ob[11]), .reset_counter(ob[12]), .decrement_counter(ob[13]),
    .count_hit(ob[14]), .count_miss(ob[15]), .count_read(ob[16]),
    .count_write(ob[17]), .count_writeback(ob[18])
  );

  int checks = 0;
  int failures = 0;

  // Per-request observations gathered by run_req
  int r_cyc, r_done, r_read, r_write, r_hit, r_miss, r_wb, r_lru, r_pw, r_dec;
  int r_fin, r_clear_dirty, r_victim, r_victim_bad, r_wb_words, r_ld_words;
  int r_wb_last_clears, r_pw_at_ful, r_sd_at_ful, r_cw_at_ful, r_abort_zero;

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic run_req(input logic st, input logic hit, input logic dirty,
                         input int lat, input int abort_word);
    int cnt = 7;
    int lat_cnt = 0;
    bit installed = 0;
    r_cyc = 0; r_done = 0; r_read = 0; r_write = 0; r_hit = 0; r_miss = 0;
    r_wb = 0; r_lru = 0; r_pw = 0; r_dec = 0; r_fin = 0; r_clear_dirty = 0;
    r_victim = 0; r_victim_bad = 0; r_wb_words = 0; r_ld_words = 0;
    r_wb_last_clears = 0; r_pw_at_ful = 0; r_sd_at_ful = 0; r_cw_at_ful = 0;
    r_abort_zero = 0;
    req_valid    = 1'b1;
    req_is_store = st;
    while (r_done == 0 && r_cyc < 200) begin
      valid_block_match  = hit | installed;
      valid_dirty_bit    = dirty;
      counter_done       = (cnt == 0);
      hmem_req_fulfilled = 1'b0;
      #1;
      if (w_hmem_valid && lat_cnt == lat - 1) hmem_req_fulfilled = 1'b1;
      #1;
      if (abort_word > 0 && r_ld_words == abort_word - 1 && w_hmem_valid && !w_hmem_store) begin
        reset = 1'b0;
        #1;
        r_abort_zero = (o === 19'd0);
        @(posedge clk); #1;
        reset     = 1'b1;
        req_valid = 1'b0;
        hmem_req_fulfilled = 1'b0;
        return;
      end
      r_read  += int'(w_count_read);
      r_write += int'(w_count_write);
      r_hit   += int'(w_count_hit);
      r_miss  += int'(w_count_miss);
      r_wb    += int'(w_count_wb);
      r_lru   += int'(w_lru);
      r_pw    += int'(w_perform_write);
      r_dec   += int'(w_decrement);
      r_fin   += int'(w_finish);
      r_clear_dirty += int'(w_clear_dirty);
      r_victim      += int'(w_victim);
      if (w_victim && w_miss_recovery) r_victim_bad++;
      if (w_hmem_valid && hmem_req_fulfilled) begin
        if (w_hmem_store) begin
          r_wb_words++;
          if (cnt == 0 && w_clear_dirty && w_clear_valid) r_wb_last_clears++;
        end else begin
          r_ld_words++;
        end
      end
      if (w_req_fulfilled) begin
        r_pw_at_ful = int'(w_perform_write);
        r_sd_at_ful = int'(w_set_dirty);
        r_cw_at_ful = int'(w_count_write);
        r_done = 1;
      end
      if (w_hmem_valid) lat_cnt = hmem_req_fulfilled ? 0 : lat_cnt + 1;
      else lat_cnt = 0;
      if (w_reset_counter) cnt = 7;
      else if (w_decrement) cnt--;
      if (w_finish) installed = 1;
      r_cyc++;
      @(posedge clk); #1;
    end
    req_valid          = 1'b0;
    hmem_req_fulfilled = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; hmem_req_fulfilled = 1'b0;
    valid_block_match = 1'b0; valid_dirty_bit = 1'b0; counter_done = 1'b0; sel_ro = 1'b0;
    #1;
    checks++; if (o !== 19'd0) begin failures++; $display("FAIL reset_outs got=%h exp=0", o); end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++; if (o !== 19'd0) begin failures++; $display("FAIL idle_outs got=%h exp=0", o); end
    @(posedge clk); #1;
  endtask

  task automatic test_load_hit();
    run_req(1'b0, 1'b1, 1'b0, 1, 0);
    checks++; if (r_done !== 1) begin failures++; $display("FAIL lh_done got=%0d exp=1", r_done); end
    checks++; if (r_cyc !== 2) begin failures++; $display("FAIL lh_latency got=%0d exp=2", r_cyc); end
    checks++; if (r_read !== 1) begin failures++; $display("FAIL lh_count_read got=%0d exp=1", r_read); end
    checks++; if (r_hit !== 1) begin failures++; $display("FAIL lh_count_hit got=%0d exp=1", r_hit); end
    checks++; if (r_lru !== 1) begin failures++; $display("FAIL lh_lru got=%0d exp=1", r_lru); end
    checks++; if (r_pw !== 0) begin failures++; $display("FAIL lh_perform_write got=%0d exp=0", r_pw); end
  endtask

  task automatic test_store_hit();
    run_req(1'b1, 1'b1, 1'b0, 1, 0);
    checks++; if (r_done !== 1) begin failures++; $display("FAIL sh_done got=%0d exp=1", r_done); end
    checks++; if (r_pw_at_ful !== 1) begin failures++; $display("FAIL sh_perform_write got=%0d exp=1", r_pw_at_ful); end
    checks++; if (r_sd_at_ful !== 1) begin failures++; $display("FAIL sh_set_dirty got=%0d exp=1", r_sd_at_ful); end
    checks++; if (r_cw_at_ful !== 1) begin failures++; $display("FAIL sh_count_write got=%0d exp=1", r_cw_at_ful); end
    checks++; if (r_read !== 0) begin failures++; $display("FAIL sh_count_read got=%0d exp=0", r_read); end
  endtask

  task automatic test_back_to_back();
    run_req(1'b0, 1'b1, 1'b0, 1, 0);
    run_req(1'b1, 1'b1, 1'b0, 1, 0);
    checks++; if (r_done !== 1) begin failures++; $display("FAIL b2b_done got=%0d exp=1", r_done); end
    checks++; if (r_cyc !== 2) begin failures++; $display("FAIL b2b_latency got=%0d exp=2", r_cyc); end
  endtask

  task automatic test_clean_miss();
    run_req(1'b0, 1'b0, 1'b0, 1, 0);
    checks++; if (r_done !== 1) begin failures++; $display("FAIL cm_done got=%0d exp=1", r_done); end
    checks++; if (r_cyc !== 11) begin failures++; $display("FAIL cm_latency got=%0d exp=11", r_cyc); end
    checks++; if (r_miss !== 1) begin failures++; $display("FAIL cm_count_miss got=%0d exp=1", r_miss); end
    checks++; if (r_pw !== 8) begin failures++; $display("FAIL cm_perform_write got=%0d exp=8", r_pw); end
    checks++; if (r_dec !== 7) begin failures++; $display("FAIL cm_decrement got=%0d exp=7", r_dec); end
    checks++; if (r_fin !== 1) begin failures++; $display("FAIL cm_finish got=%0d exp=1", r_fin); end
    checks++; if (r_hit !== 0) begin failures++; $display("FAIL cm_count_hit got=%0d exp=0", r_hit); end
    checks++; if (r_read !== 1) begin failures++; $display("FAIL cm_count_read got=%0d exp=1", r_read); end
  endtask

  task automatic test_dirty_miss();
    run_req(1'b1, 1'b0, 1'b1, 3, 0);
    checks++; if (r_done !== 1) begin failures++; $display("FAIL dm_done got=%0d exp=1", r_done); end
    checks++; if (r_wb_words !== 8) begin failures++; $display("FAIL dm_store_words got=%0d exp=8", r_wb_words); end
    checks++; if (r_ld_words !== 8) begin failures++; $display("FAIL dm_load_words got=%0d exp=8", r_ld_words); end
    checks++; if (r_wb_last_clears !== 1) begin failures++; $display("FAIL dm_last_clears got=%0d exp=1", r_wb_last_clears); end
    checks++; if (r_clear_dirty !== 1) begin failures++; $display("FAIL dm_clear_dirty got=%0d exp=1", r_clear_dirty); end
    checks++; if (r_wb !== 1) begin failures++; $display("FAIL dm_count_wb got=%0d exp=1", r_wb); end
    checks++; if (r_victim !== 1) begin failures++; $display("FAIL dm_victim got=%0d exp=1", r_victim); end
    checks++; if (r_victim_bad !== 0) begin failures++; $display("FAIL dm_victim_late got=%0d exp=0", r_victim_bad); end
    checks++; if (r_dec !== 14) begin failures++; $display("FAIL dm_decrement got=%0d exp=14", r_dec); end
    checks++; if (r_pw_at_ful !== 1) begin failures++; $display("FAIL dm_replay_write got=%0d exp=1", r_pw_at_ful); end
  endtask

  task automatic test_reset_mid_fill();
    run_req(1'b0, 1'b0, 1'b0, 1, 4);
    checks++; if (r_abort_zero !== 1) begin failures++; $display("FAIL rm_outs_zero got=%0d exp=1", r_abort_zero); end
    run_req(1'b0, 1'b0, 1'b0, 1, 0);
    checks++; if (r_done !== 1) begin failures++; $display("FAIL rm_done got=%0d exp=1", r_done); end
    checks++; if (r_miss !== 1) begin failures++; $display("FAIL rm_count_miss got=%0d exp=1", r_miss); end
    checks++; if (r_read !== 1) begin failures++; $display("FAIL rm_count_read got=%0d exp=1", r_read); end
    checks++; if (r_cyc !== 11) begin failures++; $display("FAIL rm_latency got=%0d exp=11", r_cyc); end
  endtask

  task automatic test_read_only();
    reset = 1'b0;
    @(posedge clk); #1;
    reset  = 1'b1;
    sel_ro = 1'b1;
    @(posedge clk); #1;
    run_req(1'b1, 1'b0, 1'b1, 1, 0);
    checks++; if (r_done !== 1) begin failures++; $display("FAIL ro_done got=%0d exp=1", r_done); end
    checks++; if (r_wb !== 0) begin failures++; $display("FAIL ro_count_wb got=%0d exp=0", r_wb); end
    checks++; if (r_wb_words !== 0) begin failures++; $display("FAIL ro_store_words got=%0d exp=0", r_wb_words); end
    checks++; if (r_ld_words !== 8) begin failures++; $display("FAIL ro_load_words got=%0d exp=8", r_ld_words); end
    checks++; if (r_pw_at_ful !== 0) begin failures++; $display("FAIL ro_final_write got=%0d exp=0", r_pw_at_ful); end
    checks++; if (r_cyc !== 11) begin failures++; $display("FAIL ro_latency got=%0d exp=11", r_cyc); end
  endtask

  initial begin
    test_reset();
    test_load_hit();
    test_store_hit();
    test_back_to_back();
    test_clean_miss();
    test_dirty_miss();
    test_reset_mid_fill();
    test_read_only();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Sequencing FSM for the cache datapath.
- Accepts load/store requests from the requester side, resolves hit/miss from metadata status, and runs dirty-victim writeback and line refill against higher memory one word per handshake.
- Drives every datapath control strobe, including the perf-counter pulses.
- Instantiated alongside the datapath inside the cache top, wired through cache_internal_if; the controller end is flattened to the ports below.

Parameters:
- READ_ONLY, 0: 1 removes writeback and store paths; a store is fulfilled as a load with no data write.
- COUNT_REPLAY_HIT, 0: 1 lets the post-refill replay pulse count_hit.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset; forces IDLE.
- req_valid  in  1  requester request; held with address/op stable until req_fulfilled.
- req_is_store  in  1  1 store, 0 load.
- req_fulfilled  out  1  one-cycle completion pulse.
- hmem_req_valid  out  1  higher-memory word request.
- hmem_req_is_store  out  1  1 writeback word, 0 refill word.
- hmem_req_fulfilled  in  1  higher-memory word done; for refill, loaded word valid this cycle.
- valid_block_match  in  1  metadata: tag hit in addressed set.
- valid_dirty_bit  in  1  metadata: selected victim valid and dirty.
- counter_done  in  1  word counter at 0 (last word).
- Datapath control outputs, each 1 bit: miss_recovery_mode, process_lru_counters, clear_selected_valid_bit, finish_new_line_install, clear_selected_dirty_bit, set_selected_dirty_bit, set_hmem_block_address, use_victim_tag_for_hmem_block_address, perform_write, reset_counter, decrement_counter.
- Perf-counter pulses, each 1 bit: count_hit, count_miss, count_read, count_write, count_writeback.

Behaviour:
- Reset: state=IDLE, replay=0. All outputs are combinational from state plus inputs and are therefore 0 in IDLE with req_valid=0.
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE.
- IDLE: if req_valid, go to COMPARE. No outputs.
- COMPARE, first pass (replay=0): pulse count_read (load) or count_write (store).
- COMPARE, hit (valid_block_match=1):
  - Pulse process_lru_counters and req_fulfilled.
  - Pulse count_hit unless replay=1 and COUNT_REPLAY_HIT=0.
  - If store and !READ_ONLY: perform_write=1 and set_selected_dirty_bit=1.
  - Next: IDLE, replay<=0.
  - Hit latency: accept at cycle N, req_fulfilled at N+1.
- COMPARE, miss (replay=0 guaranteed): pulse count_miss, set_hmem_block_address, reset_counter.
  - If valid_dirty_bit and !READ_ONLY: use_victim_tag_for_hmem_block_address=1, count_writeback=1, go to WRITEBACK.
  - Else: clear_selected_valid_bit=1, go to ALLOCATE.
- WRITEBACK: miss_recovery_mode=1, hmem_req_valid=1, hmem_req_is_store=1.
  - On hmem_req_fulfilled with !counter_done: decrement_counter.
  - On hmem_req_fulfilled with counter_done: clear_selected_dirty_bit, clear_selected_valid_bit, set_hmem_block_address (use_victim=0, loads the request tag), reset_counter; go to ALLOCATE.
- ALLOCATE: miss_recovery_mode=1, hmem_req_valid=1, hmem_req_is_store=0.
  - On hmem_req_fulfilled: perform_write=1, storing the loaded word at the counter index.
  - If !counter_done: decrement_counter.
  - If counter_done: finish_new_line_install=1, replay<=1, go to COMPARE.
- hmem_req_valid stays continuously high across words in one phase. Each hmem_req_fulfilled cycle consumes exactly one word. Unbounded wait with no timeout.
- A miss with valid_block_match=0 during replay is a protocol error. The bench flags it; the FSM repeats the miss path.
- req_valid is not sampled outside IDLE. Dropping it mid-miss does not abort; the line fill completes and req_fulfilled still pulses.
- Back-to-back: a new req_valid in the cycle after req_fulfilled is accepted (IDLE→COMPARE), giving a 2-cycle minimum request spacing.
- Asynchronous reset mid-WRITEBACK/ALLOCATE: immediate IDLE with outputs 0. The partial line is left invalid because the valid bit was already cleared.
- hmem_req_fulfilled while hmem_req_valid=0 is ignored.

Test Plan:
- Load hit: req_valid=1, load, match=1. Expect req_fulfilled at cycle 2, count_read=1, count_hit=1, process_lru_counters=1, perform_write=0.
- Store hit: same with store. Expect perform_write=1, set_selected_dirty_bit=1 and count_write=1 in the same cycle as req_fulfilled.
- Clean miss, 8-word line: match=0, dirty=0, hmem fulfils every cycle, counter_done on 8th word. Expect count_miss=1, 8 perform_write pulses, 7 decrement_counter, finish_new_line_install once, replay hit with count_hit=0, req_fulfilled 11 cycles after accept.
- Dirty miss, hmem 3-cycle latency per word: expect 8 store handshakes, clear_selected_dirty_bit and clear_selected_valid_bit on the last, then 8 loads. Expect count_writeback=1 and use_victim_tag asserted only in the COMPARE miss cycle.
- Reset low during ALLOCATE word 4: all outputs 0 immediately. After release with req_valid, restart from COMPARE with count_miss pulsed again.
- READ_ONLY=1 store miss with dirty=1: expect no WRITEBACK, no count_writeback, refill only, req_fulfilled with perform_write=0 in the final COMPARE.
